// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port memory between the IFU and the LSU
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int WDT_W = 4,
  parameter logic [WDT_W-1:0] IFU_WDT = 4'b0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  input  logic              ifu_flush,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [WDT_W-1:0]  lsu_wdt,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [WDT_W-1:0]  wdt_op,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_LS} state_t;
  state_t state_q, state_d;
  logic last_lsu_q, last_lsu_d;
  logic store_q, store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic idle, grant_ifu, grant_lsu;
  // Gating with rst_n keeps every output low while reset is held, even with requests pending.
  assign idle = rst_n && state_q == IDLE;
  assign grant_ifu = idle && ifu_req_valid && (!lsu_req_valid || last_lsu_q);
  assign grant_lsu = idle && lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
  // State and latched access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_lsu_q <= 1'b0;
      store_q <= 1'b0;
      addr_q <= '0;
      wdt_q <= '0;
    end else begin
      state_q <= state_d;
      last_lsu_q <= last_lsu_d;
      store_q <= store_d;
      addr_q <= addr_d;
      wdt_q <= wdt_d;
    end
  end
  // Next state and memory/requester outputs; response cycles replay the latched address and width.
  always_comb begin
    state_d = state_q;
    last_lsu_d = last_lsu_q;
    store_d = store_q;
    addr_d = addr_q;
    wdt_d = wdt_q;
    ifu_req_ready = grant_ifu;
    lsu_req_ready = grant_lsu;
    ifu_resp_valid = 1'b0;
    ifu_resp_data = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data = '0;
    mem_ren = 1'b0;
    mem_raddr = '0;
    mem_wen = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    wdt_op = '0;
    if (grant_ifu) begin
      mem_ren = 1'b1;
      mem_raddr = ifu_addr;
      wdt_op = IFU_WDT;
      addr_d = ifu_addr;
      wdt_d = IFU_WDT;
      last_lsu_d = 1'b0;
      store_d = 1'b0;
      state_d = RESP_IF;
    end else if (grant_lsu) begin
      mem_ren = !lsu_wen;
      mem_raddr = lsu_wen ? '0 : lsu_addr;
      mem_wen = lsu_wen;
      mem_waddr = lsu_wen ? lsu_addr : '0;
      mem_wdata = lsu_wen ? lsu_wdata : '0;
      wdt_op = lsu_wdt;
      addr_d = lsu_addr;
      wdt_d = lsu_wdt;
      last_lsu_d = 1'b1;
      store_d = lsu_wen;
      state_d = RESP_LS;
    end else if (state_q == RESP_IF) begin
      mem_raddr = addr_q;
      wdt_op = wdt_q;
      ifu_resp_valid = !ifu_flush;
      ifu_resp_data = ifu_flush ? '0 : mem_rdata;
      state_d = IDLE;
    end else if (state_q == RESP_LS) begin
      mem_raddr = addr_q;
      wdt_op = wdt_q;
      lsu_resp_valid = 1'b1;
      lsu_resp_data = store_q ? '0 : mem_rdata;
      state_d = IDLE;
    end
  end
endmodule
